// File: rtl/npu_mem_pkg.sv
// Shared types for the NPU operand/result SRAM banks.
// Clear-sequencer states and latency limits.
package npu_mem_pkg;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    localparam int MAX_READ_LAT = 2;

endpackage

// File: rtl/sram_bank_if.sv
// Access and clear-control bundle between the NPU controller and an SRAM bank.
// The controller is the master; the bank is the slave.
interface sram_bank_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              ce;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] din;
    logic [DATA_W-1:0] dout;
    logic              rvalid;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output ce, we, addr, din, clr_req,
        input  dout, rvalid, clr_busy, clr_done
    );

    modport slave (
        input  ce, we, addr, din, clr_req,
        output dout, rvalid, clr_busy, clr_done
    );
endinterface

// File: rtl/sram_bank_array.sv
// Inferable single-port RAM: one write port, registered read-first output.
// No reset on the storage or the read register.
module sram_bank_array #(
    parameter int    DATA_W    = 8,
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = "",
    localparam int   ADDR_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        if (re) rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/sram_bank.sv
// Parametrised SRAM bank with hardware zero-fill sequencer and
// a 1- or 2-stage read-valid pipeline.
module sram_bank
    import npu_mem_pkg::*;
#(
    parameter int    DATA_W    = 8,
    parameter int    DEPTH     = 1024,
    parameter int    READ_LAT  = 1,
    parameter string INIT_FILE = ""
) (
    input  logic       clk,
    input  logic       rst,
    sram_bank_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    generate
        if (READ_LAT < 1 || READ_LAT > MAX_READ_LAT) begin : g_bad_lat
            $error("sram_bank: READ_LAT must be 1 or 2");
        end
        if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("sram_bank: DEPTH must be a power of two >= 4");
        end
    endgenerate

    clr_state_t        state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              v1_q, v1_d;
    logic              busy, done, acc;
    logic              arr_we;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;

    assign busy = (state_q == CLR_RUN);
    assign done = busy && (ptr_q == LAST);
    assign acc  = bus.ce && !busy;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            CLR_IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLR_RUN;
                    ptr_d   = '0;
                end
            end
            CLR_RUN: begin
                if (done) begin
                    state_d = CLR_IDLE;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
        endcase
    end

    // Clear path owns the array port whenever the sequencer runs.
    always_comb begin
        arr_we    = busy || (acc && bus.we);
        arr_addr  = busy ? ptr_q : bus.addr;
        arr_wdata = busy ? '0 : bus.din;
        v1_d      = acc && !bus.we;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLR_IDLE;
            ptr_q   <= '0;
            v1_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            v1_q    <= v1_d;
        end
    end

    sram_bank_array #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (acc),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic [DATA_W-1:0] dout2_q, dout2_d;
            logic              v2_q;
            always_comb dout2_d = v1_q ? arr_rdata : dout2_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout2_q <= '0;
                    v2_q    <= 1'b0;
                end else begin
                    dout2_q <= dout2_d;
                    v2_q    <= v1_q;
                end
            end
            assign bus.dout   = dout2_q;
            assign bus.rvalid = v2_q;
        end else begin : g_lat1
            // Array read register has no reset; mask it until first access.
            logic seen_q, seen_d;
            always_comb seen_d = seen_q || acc;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) seen_q <= 1'b0;
                else     seen_q <= seen_d;
            end
            assign bus.dout   = seen_q ? arr_rdata : '0;
            assign bus.rvalid = v1_q;
        end
    endgenerate

    assign bus.clr_busy = busy;
    assign bus.clr_done = done;
endmodule

// File: tb/tb_sram_bank.sv
// Directed scoreboard bench for sram_bank in three configurations.
// Reads push expected data; outputs are popped and compared one cycle later.
module tb_sram_bank;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   fails  = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    sram_bank_if #(.DATA_W(8),  .ADDR_W(10)) b1 ();
    sram_bank_if #(.DATA_W(16), .ADDR_W(4))  b2 ();
    sram_bank_if #(.DATA_W(8),  .ADDR_W(4))  b3 ();

    sram_bank #(.DATA_W(8), .DEPTH(1024), .READ_LAT(1), .INIT_FILE(""))
        d1 (.clk(clk), .rst(rst), .bus(b1.slave));
    sram_bank #(.DATA_W(16), .DEPTH(16), .READ_LAT(2), .INIT_FILE(""))
        d2 (.clk(clk), .rst(rst), .bus(b2.slave));
    sram_bank #(.DATA_W(8), .DEPTH(16), .READ_LAT(1), .INIT_FILE(""))
        d3 (.clk(clk), .rst(rst), .bus(b3.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag, input logic rv,
                           input logic [15:0] obs);
        logic [15:0] e;
        chk({tag, "_rvalid"}, {15'd0, rv}, 16'd1);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 16'd1, 16'd0);
        end else begin
            e = sb.pop_front();
            chk(tag, obs, e);
        end
    endtask

    task automatic idle_all();
        b1.ce = 0; b1.we = 0; b1.addr = '0; b1.din = '0; b1.clr_req = 0;
        b2.ce = 0; b2.we = 0; b2.addr = '0; b2.din = '0; b2.clr_req = 0;
        b3.ce = 0; b3.we = 0; b3.addr = '0; b3.din = '0; b3.clr_req = 0;
    endtask

    task automatic wr3(input logic [3:0] a, input logic [7:0] d);
        b3.ce = 1; b3.we = 1; b3.addr = a; b3.din = d;
        tick();
        b3.ce = 0; b3.we = 0;
    endtask

    initial begin
        int busy_cnt;
        int done_cnt;
        int rv_seen;
        idle_all();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_d1_dout", {8'd0, b1.dout}, 16'h0);
        chk("rst_d1_rvalid", {15'd0, b1.rvalid}, 16'h0);
        chk("rst_d2_dout", b2.dout, 16'h0);
        chk("rst_d3_busy", {15'd0, b3.clr_busy}, 16'h0);
        chk("rst_d3_done", {15'd0, b3.clr_done}, 16'h0);
        rst = 1'b0;
        tick();

        // Write 0xA5 at the top address, read it back.
        b1.ce = 1; b1.we = 1; b1.addr = 10'h3FF; b1.din = 8'hA5;
        tick();
        chk("wr_no_rvalid", {15'd0, b1.rvalid}, 16'h0);
        b1.we = 0; sb.push_back(16'h00A5);
        tick();
        b1.ce = 0;
        chk_pop("rd_3ff", b1.rvalid, {8'd0, b1.dout});
        tick();
        chk("rvalid_drop", {15'd0, b1.rvalid}, 16'h0);
        chk("dout_hold", {8'd0, b1.dout}, 16'h00A5);

        // Read-first on a write to the same address.
        b1.ce = 1; b1.we = 1; b1.addr = 10'd5; b1.din = 8'h11;
        tick();
        b1.din = 8'h22;
        tick();
        chk("rf_old_data", {8'd0, b1.dout}, 16'h0011);
        chk("rf_no_rvalid", {15'd0, b1.rvalid}, 16'h0);
        b1.we = 0; sb.push_back(16'h0022);
        tick();
        b1.ce = 0;
        chk_pop("rf_new_data", b1.rvalid, {8'd0, b1.dout});

        // READ_LAT=2 back-to-back reads.
        for (int i = 0; i < 3; i++) begin
            b2.ce = 1; b2.we = 1; b2.addr = 4'(i); b2.din = 16'h1000 + 16'(i);
            tick();
        end
        b2.we = 0;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                b2.ce = 1; b2.addr = 4'(i); sb.push_back(16'h1000 + 16'(i));
            end else begin
                b2.ce = 0;
            end
            tick();
            if (i >= 1 && i <= 3) chk_pop("lat2_b2b", b2.rvalid, b2.dout);
            else chk("lat2_rvalid_low", {15'd0, b2.rvalid}, 16'h0);
        end
        chk("lat2_dout_hold", b2.dout, 16'h1002);

        // Clear with a simultaneous write and a second request mid-clear.
        for (int i = 0; i < 16; i++) wr3(4'(i), 8'h40 + 8'(i));
        b3.clr_req = 1; b3.ce = 1; b3.we = 1; b3.addr = 4'd3; b3.din = 8'h7E;
        tick();
        b3.clr_req = 0; b3.we = 0;
        busy_cnt = 0; done_cnt = 0; rv_seen = 0;
        for (int k = 0; k < 40; k++) begin
            if (!b3.clr_busy) break;
            busy_cnt++;
            if (b3.clr_done) done_cnt++;
            if (b3.rvalid) rv_seen++;
            b3.ce = 1; b3.addr = 4'(k); b3.clr_req = (k == 5);
            tick();
        end
        b3.ce = 0; b3.clr_req = 0;
        if (b3.rvalid) rv_seen++;
        chk("clr_busy_cycles", 16'(busy_cnt), 16'd16);
        chk("clr_done_pulses", 16'(done_cnt), 16'd1);
        chk("clr_no_rvalid", 16'(rv_seen), 16'd0);
        for (int i = 0; i < 16; i++) begin
            b3.ce = 1; b3.addr = 4'(i); sb.push_back(16'h0);
            tick();
            chk_pop("clr_zero", b3.rvalid, {8'd0, b3.dout});
        end
        b3.ce = 0;

        // Reset at ptr=8 leaves the upper half intact.
        for (int i = 0; i < 16; i++) wr3(4'(i), 8'h80 + 8'(i));
        b3.clr_req = 1;
        tick();
        b3.clr_req = 0;
        for (int k = 0; k < 8; k++) tick();
        rst = 1'b1;
        #1;
        chk("midrst_busy", {15'd0, b3.clr_busy}, 16'h0);
        chk("midrst_done", {15'd0, b3.clr_done}, 16'h0);
        chk("midrst_rvalid", {15'd0, b3.rvalid}, 16'h0);
        chk("midrst_dout", {8'd0, b3.dout}, 16'h0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            b3.ce = 1; b3.addr = 4'(i);
            sb.push_back(i < 8 ? 16'h0 : 16'h0080 + 16'(i));
            tick();
            chk_pop("midrst_mem", b3.rvalid, {8'd0, b3.dout});
        end
        b3.ce = 0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
